ifid_skid_stage: RTL and testbench

Parametrised successor to the IF/ID pipeline register. It carries instruction and PC from fetch to decode through a two-entry skid buffer with a valid/ready handshake in place of a bare write-enable. It adds synchronous flush with bubble insertion and a registered `in_ready` with no combinational path from `out_ready`. It sits between the fetch unit and the decode stage, and can be reused for any instruction-carrying pipeline boundary.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/stage_entry_reg.sv | 21 ++
 rtl/ifid_skid_stage.sv | 120 ++++++++++++
 tb/tb_ifid_skid_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for instruction-carrying pipeline boundaries.
package pipe_pkg;

    // Fill level of a two-entry skid stage.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_t;

    localparam int          DEFAULT_INSTR_W = 32;
    localparam int          DEFAULT_PC_W    = 32;
    localparam logic [31:0] DEFAULT_NOP     = 32'h0000_0000;

    // Default-width entry. A stage with other widths declares its own packed
    // struct with the same {instr, pc} layout.
    typedef struct packed {
        logic [DEFAULT_INSTR_W-1:0] instr;
        logic [DEFAULT_PC_W-1:0]    pc;
    } pipe_entry_t;

    // Number of live entries for a given state.
    function automatic logic [1:0] state_count(skid_state_t s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stage_entry_reg.sv
// Width-parametrised storage register with async active-low clear and load enable.
module stage_entry_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when load is high; clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID boundary: two-entry skid buffer with valid/ready handshake and flush.
// in_ready is decoded purely from the state register, so there is no
// combinational path from out_ready back to fetch.
module ifid_skid_stage
    import pipe_pkg::*;
#(
    parameter int                   INSTR_W   = DEFAULT_INSTR_W,
    parameter int                   PC_W      = DEFAULT_PC_W,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(DEFAULT_NOP)
) (
    input  logic               clk,
    input  logic               startin,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    pcIn,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] ins,
    output logic [PC_W-1:0]    pc,
    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    skid_state_t state;
    skid_state_t state_nxt;
    entry_t      in_entry;
    entry_t      main_d;
    entry_t      main_q;
    entry_t      skid_q;
    logic        main_load;
    logic        skid_load;
    logic        accept;
    logic        fire;

    assign in_entry  = '{instr: instruction, pc: pcIn};
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    // Next-state and load decisions; flush overrides everything and drops the
    // incoming entry, so no register is loaded in a flush cycle.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = TWO;
                    end else if (fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    stage_entry_reg #(.W(ENTRY_W)) u_main (
        .clk   (clk),
        .rst_n (startin),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    stage_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .rst_n (startin),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    // The main entry drives decode; pc is left showing its last value when empty.
    assign ins       = out_valid ? main_q.instr : NOP_INSTR;
    assign pc        = main_q.pc;
    assign occupancy = state_count(state);

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage with a FIFO queue scoreboard.
module tb_ifid_skid_stage;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [INSTR_W-1:0] NOP = '0;

    logic               clk = 1'b0;
    logic               startin;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pcIn;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] ins;
    logic [PC_W-1:0]    pc;
    logic [1:0]         occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ent_t;

    ent_t q[$];

    // Results of the most recent tick.
    logic         t_fire;
    logic         t_accept;
    logic         t_missing;
    ent_t         t_got;
    ent_t         t_exp;

    always #5 clk = ~clk;

    ifid_skid_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .startin     (startin),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pcIn        (pcIn),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ins         (ins),
        .pc          (pc),
        .occupancy   (occupancy)
    );

    // One clock cycle: sample handshake before the edge, then update the
    // scoreboard queue (pop on fire, push on accept, clear on flush).
    task automatic tick();
        logic fl;
        t_accept  = in_valid & in_ready;
        t_fire    = out_valid & out_ready;
        t_got     = '{instr: ins, pc: pc};
        fl        = flush;
        t_missing = 1'b0;
        t_exp     = '0;
        @(posedge clk);
        @(negedge clk);
        if (t_fire) begin
            if (q.size() == 0) t_missing = 1'b1;
            else t_exp = q.pop_front();
        end
        if (t_accept && !fl) q.push_back('{instr: instruction, pc: pcIn});
        if (fl) q.delete();
    endtask

    task automatic drive(logic v, logic [INSTR_W-1:0] i, logic [PC_W-1:0] p);
        in_valid    = v;
        instruction = i;
        pcIn        = p;
    endtask

    task automatic test_reset();
        startin = 1'b0;
        drive(1'b0, '0, '0);
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (ins !== 32'd0) begin n_bad++; $display("FAIL reset_ins got %0d want 0", ins); end
        n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %0d want 0", pc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    endtask

    task automatic test_single();
        startin = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 32'd30, 32'd8);
        tick();
        drive(1'b0, '0, '0);
        n_cmp++; if (out_valid !== 1'b1 || ins !== 32'd30 || pc !== 32'd8) begin
            n_bad++; $display("FAIL single_out got v=%0b ins=%0d pc=%0d want v=1 ins=30 pc=8", out_valid, ins, pc);
        end
        tick();
        n_cmp++; if (!t_fire || t_missing || t_got !== t_exp) begin
            n_bad++; $display("FAIL single_fire got fire=%0b ins=%0d want ins=%0d", t_fire, t_got.instr, t_exp.instr);
        end
        n_cmp++; if (out_valid !== 1'b0 || ins !== NOP) begin
            n_bad++; $display("FAIL single_drain got v=%0b ins=%0d want v=0 ins=0", out_valid, ins);
        end
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i + 1), 32'(i * 4));
            tick();
        end
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_full got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready);
        end
        n_cmp++; if (q.size() != 2 || ins !== 32'd1) begin
            n_bad++; $display("FAIL stall_held got accepted=%0d ins=%0d want accepted=2 ins=1", q.size(), ins);
        end
        // entry 3 stays on the input until it is accepted
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (t_accept) drive(1'b0, '0, '0);
            n_cmp++; if (!t_fire || t_missing || t_got.instr !== 32'(i + 1) || t_got !== t_exp) begin
                n_bad++; $display("FAIL stall_drain_%0d got fire=%0b ins=%0d want fire=1 ins=%0d", i, t_fire, t_got.instr, i + 1);
            end
        end
        drive(1'b0, '0, '0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h40 + 32'(i * 4));
            if (in_ready !== 1'b1) errs++;
            tick();
            if (out_valid !== 1'b1 || ins !== 32'h100 + 32'(i) || pc !== 32'h40 + 32'(i * 4)) errs++;
            if (i > 0 && (!t_fire || t_missing || t_got !== t_exp)) errs++;
        end
        drive(1'b0, '0, '0);
        tick();
        if (!t_fire || t_missing || t_got !== t_exp) errs++;
        n_cmp++; if (errs != 0 || q.size() != 0) begin
            n_bad++; $display("FAIL back_to_back got errors=%0d left=%0d want 0/0", errs, q.size());
        end
    endtask

    task automatic test_flush_two();
        int seen99 = 0;
        out_ready = 1'b0;
        drive(1'b1, 32'd101, 32'h10); tick();
        drive(1'b1, 32'd102, 32'h14); tick();
        flush = 1'b1;
        drive(1'b1, 32'd99, 32'h18);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        n_cmp++; if (out_valid !== 1'b0 || ins !== NOP || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_two got v=%0b ins=%0d occ=%0d rdy=%0b want 0/0/0/1", out_valid, ins, occupancy, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1 && ins === 32'd99) seen99++;
            tick();
        end
        n_cmp++; if (seen99 != 0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_no99 got seen=%0d v=%0b want 0/0", seen99, out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'd7, 32'h70); tick();
        drive(1'b1, 32'd8, 32'h74); tick();
        drive(1'b0, '0, '0);
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL areset_pre got occ=%0d want 2", occupancy); end
        #2;
        startin = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || pc !== 32'd0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_bad++; $display("FAIL areset_now got v=%0b pc=%0d rdy=%0b occ=%0d want 0/0/1/0", out_valid, pc, in_ready, occupancy);
        end
        q.delete();
        @(negedge clk);
        startin = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int errs = 0;
        int fires = 0;
        int accepts = 0;
        logic [INSTR_W-1:0] seq = 32'h1000;
        in_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!in_valid || in_ready) begin
                drive(1'($urandom_range(0, 2) != 0), seq, seq << 2);
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
            tick();
            if (t_accept && !flush) begin accepts++; seq++; end
            else if (t_accept) seq++;
            if (t_fire) fires++;
            if (t_fire && (t_missing || t_got !== t_exp)) errs++;
            if (occupancy > 2'd2 || 32'(occupancy) != q.size()) errs++;
            if (in_ready !== (q.size() != 2)) errs++;
            if (out_valid !== (q.size() != 0)) errs++;
            if (q.size() != 0 && ins !== q[0].instr) errs++;
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (t_fire) fires++;
            if (t_fire && (t_missing || t_got !== t_exp)) errs++;
        end
        n_cmp++; if (errs != 0) begin
            n_bad++; $display("FAIL random_scoreboard got errors=%0d want 0 (fires=%0d accepts=%0d)", errs, fires, accepts);
        end
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL random_drain got left=%0d v=%0b want 0/0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_fill();
        test_back_to_back();
        test_flush_two();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
